// File: rtl/mult_initiator_pkg.sv
// Shared constants for mult_initiator: FSM state encoding and default parameter values.
package mult_initiator_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_DEPTH          = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_initiator_if.sv
// Bundles the upstream operand port, the multiplier handshake and the downstream product port.
interface mult_initiator_if
  import mult_initiator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               valid_data;
  logic               Done_Flag;
  logic [2*WIDTH-1:0] producto;
  logic               ack;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_producto;
  logic               timeout_err;

  modport master (
    input  in_valid, in_a, in_b, Done_Flag, producto, out_ready,
    output in_ready, a, b, valid_data, ack, out_valid, out_producto, timeout_err
  );

  modport slave (
    output in_valid, in_a, in_b, Done_Flag, producto, out_ready,
    input  in_ready, a, b, valid_data, ack, out_valid, out_producto, timeout_err
  );

endinterface

// File: rtl/mult_operand_fifo.sv
// Operand-pair buffer: DEPTH entries with wrap-around pointers carrying an extra lap bit for full/empty.
module mult_operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // Same slot index but different lap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/mult_initiator.sv
// Feeds buffered operand pairs to a REQ/ACK-handshake multiplier and holds each product for downstream.
// Define MULT_INIT_TIMEOUT_EN to add a sticky watchdog on the REQ phase.
module mult_initiator
  import mult_initiator_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  mult_initiator_if.master bus
);

  state_t             state;
  state_t             state_next;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [2*WIDTH-1:0] head;
  logic               timeout_hit;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               valid_data;
  logic               ack;
  logic               out_valid;

  // in_ready depends only on occupancy, so a pop never makes room for a same-cycle write into a full buffer.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  mult_operand_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.Done_Flag)
          state_next = ACK;
        else if (timeout_hit)
          state_next = IDLE;
      end
      ACK: begin
        if (!bus.Done_Flag)
          state_next = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    valid_data = 1'b0;
    ack        = 1'b0;
    out_valid  = 1'b0;
    case (state)
      REQ:     valid_data = 1'b1;
      ACK:     ack        = 1'b1;
      OUT:     out_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      if (pop)
        {a_q, b_q} <= head;
      if (state == REQ && bus.Done_Flag)
        prod_q <= bus.producto;
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.out_producto = prod_q;
  assign bus.valid_data   = valid_data;
  assign bus.ack          = ack;
  assign bus.out_valid    = out_valid;

`ifdef MULT_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] req_cnt;
  logic             timeout_q;

  // Fires on the last permitted REQ cycle, so valid_data is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state == REQ) && !bus.Done_Flag &&
                       (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == REQ && state_next == REQ)
        req_cnt <= req_cnt + CNT_W'(1);
      else
        req_cnt <= '0;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_initiator.sv
// Self-checking bench for mult_initiator: stub multiplier, product scoreboard, vector table and random traffic.
module tb_mult_initiator;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_initiator_if #(.WIDTH(W)) bus ();

  mult_initiator #(
    .WIDTH          (W),
    .DEPTH          (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] exp_q[$];
  int             mult_lat = 1;
  bit             mult_on = 1'b1;
  bit             ack_seen = 1'b0;
  bit             drv_done;
  int             lat_cnt;

  task automatic check_output(input string name, input logic [2*W-1:0] actual, input logic [2*W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    check_output(name, 64'(actual), 64'(expected));
  endtask

  // Stub multiplier: answers after mult_lat cycles of valid_data and holds Done_Flag until it sees ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Done_Flag <= 1'b0;
      bus.producto  <= '0;
      lat_cnt       <= 0;
    end else if (bus.Done_Flag) begin
      if (bus.ack)
        bus.Done_Flag <= 1'b0;
    end else if (bus.valid_data && mult_on) begin
      if (lat_cnt >= mult_lat) begin
        bus.Done_Flag <= 1'b1;
        bus.producto  <= 64'(bus.a) * 64'(bus.b);
        lat_cnt       <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  // Reference model: every accepted pair owes one product, delivered in acceptance order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(64'(bus.in_a) * 64'(bus.in_b));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_product: got 0x%0h, expected no product", bus.out_producto);
        end else begin
          check_output("scoreboard", bus.out_producto, exp_q.pop_front());
        end
      end
      if (bus.ack)
        ack_seen = 1'b1;
      check_bit("vd_ack_exclusive", bus.valid_data && bus.ack, 1'b0);
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    bit accepted = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 500 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_accept: got in_ready=0 for 500 cycles, expected acceptance");
    end
  endtask

  task automatic wait_high(input string name, input int which);
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = bus.valid_data;
        1:       seen = bus.out_valid;
        default: seen = bus.ack;
      endcase
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got 0 until wait expired, expected 1", name);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    vec_t vecs[6];
    int   n;

    vecs[0] = '{a: 32'd34,         b: 32'd76,         prod: 64'd2584};
    vecs[1] = '{a: 32'd3,          b: 32'd5,          prod: 64'd15};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          prod: 64'h1_FFFF_FFFE};
    vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  prod: 64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{a: 32'd0,          b: 32'h1234_5678,  prod: 64'd0};
    vecs[5] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  prod: 64'h1_0000_0000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    #12;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_valid_data", bus.valid_data, 1'b0);
    check_bit("rst_ack", bus.ack, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_timeout_err", bus.timeout_err, 1'b0);
    check_output("rst_out_producto", bus.out_producto, 64'd0);
    check_output("rst_a", 64'(bus.a), 64'd0);
    check_output("rst_b", 64'(bus.b), 64'd0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single transaction 34*76");
    ack_seen = 1'b0;
    mult_lat = 2;
    apply_stimulus(32'd34, 32'd76);
    wait_high("valid_data_rise", 0);
    check_output("req_a", 64'(bus.a), 64'd34);
    check_output("req_b", 64'(bus.b), 64'd76);
    wait_high("out_valid_rise", 1);
    check_output("single_product", bus.out_producto, 64'd2584);
    check_bit("ack_pulse_seen", ack_seen, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      mult_lat = i % 3;
      apply_stimulus(vecs[i].a, vecs[i].b);
      wait_high("table_out_valid", 1);
      check_output($sformatf("table_%0d", i), bus.out_producto, vecs[i].prod);
      @(posedge clk);
      #1;
    end

    $display("[TB] back-to-back pairs into a DEPTH=2 buffer");
    mult_lat = 2;
    apply_stimulus(32'd3, 32'd5);
    apply_stimulus(32'd7, 32'd9);
    apply_stimulus(32'hFFFF_FFFF, 32'd2);
    check_bit("full_in_ready_low", bus.in_ready, 1'b0);
    wait_high("b2b_out0", 1);
    check_output("b2b_prod0", bus.out_producto, 64'd15);
    @(posedge clk);
    #1;
    wait_high("b2b_out1", 1);
    check_output("b2b_prod1", bus.out_producto, 64'd63);
    @(posedge clk);
    #1;
    wait_high("b2b_out2", 1);
    check_output("b2b_prod2", bus.out_producto, 64'h1_FFFF_FFFE);
    @(posedge clk);
    #1;

    $display("[TB] downstream stall in OUT");
    bus.out_ready = 1'b0;
    mult_lat = 1;
    apply_stimulus(32'd11, 32'd13);
    apply_stimulus(32'd17, 32'd19);
    wait_high("stall_out_valid", 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("stall_out_valid_held", bus.out_valid, 1'b1);
      check_output("stall_product_stable", bus.out_producto, 64'd143);
      check_bit("stall_no_new_req", bus.valid_data, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("stall_release_prod", bus.out_producto, 64'd143);
    @(posedge clk);
    #1;
    wait_high("stall_next_out", 1);
    check_output("stall_next_prod", bus.out_producto, 64'd323);
    @(posedge clk);
    #1;

    $display("[TB] reset during ACK");
    mult_lat = 3;
    apply_stimulus(32'd21, 32'd23);
    apply_stimulus(32'd25, 32'd27);
    wait_high("ack_before_reset", 2);
    #2 rst_n = 1'b0;
    #1;
    check_bit("midrst_ack", bus.ack, 1'b0);
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_bit("midrst_valid_data", bus.valid_data, 1'b0);
    check_bit("midrst_in_ready", bus.in_ready, 1'b1);
    check_output("midrst_a", 64'(bus.a), 64'd0);
    exp_q.delete();
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("postrst_no_req", bus.valid_data, 1'b0);
      check_bit("postrst_no_out", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

`ifdef MULT_INIT_TIMEOUT_EN
    $display("[TB] watchdog on a silent multiplier");
    mult_on = 1'b0;
    apply_stimulus(32'd5, 32'd5);
    wait_high("to_valid_data", 0);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.valid_data) break;
      n++;
    end
    check_output("to_req_cycles", 64'(n), 64'd64);
    check_bit("to_valid_data_low", bus.valid_data, 1'b0);
    check_bit("to_err_set", bus.timeout_err, 1'b1);
    if (exp_q.size() > 0)
      void'(exp_q.pop_front());
    mult_on = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(32'd6, 32'd7);
    wait_high("to_next_out", 1);
    check_output("to_next_prod", bus.out_producto, 64'd42);
    check_bit("to_err_sticky", bus.timeout_err, 1'b1);
    @(posedge clk);
    #1;
`else
    $display("[TB] REQ waits on a silent multiplier");
    mult_on = 1'b0;
    apply_stimulus(32'd6, 32'd7);
    wait_high("wait_valid_data", 0);
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check_bit("wait_req_held", bus.valid_data, 1'b1);
    end
    check_bit("wait_no_timeout_err", bus.timeout_err, 1'b0);
    mult_on = 1'b1;
    wait_high("wait_out_valid", 1);
    check_output("wait_prod", bus.out_producto, 64'd42);
    @(posedge clk);
    #1;
`endif

    $display("[TB] random traffic");
    drv_done = 1'b0;
    n = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          mult_lat = int'($urandom_range(0, 4));
          apply_stimulus(pick_operand(), pick_operand());
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while ((!drv_done || exp_q.size() > 0) && n < 5000) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          n++;
        end
      end
    join
    bus.out_ready = 1'b1;
    check_output("random_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
